vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 173 +++++++++++++++++
 tb/tb_vga_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// +----------------------------------------------------------------------------+
// | vga_capture: VGA timing lock detector, active-pixel capture, red counter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_d,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pixel_valid,
  output logic [9:0]  x_loc,
  output logic [9:0]  y_loc,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_len,
  output logic [18:0] red_pixels
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state;
  logic        hs_q, vs_q;
  logic        hs_fall, vs_fall;
  logic [9:0]  h_cnt, v_cnt, x_cnt, y_cnt;
  logic        line_act, frame_err, skip_first;
  logic [7:0]  good_cnt, good_next;
  logic [18:0] red_acc;
  logic [10:0] frame_len_now;
  logic        line_bad, frame_bad, line_err_now, watchdog, red_hit;

  always_comb begin
    hs_fall       = hs_q & ~hsync;
    vs_fall       = vs_q & ~vsync;
    line_bad      = (32'(h_cnt) + 32'd1) != H_TOTAL;
    frame_len_now = {1'b0, v_cnt} + {10'd0, hs_fall};
    frame_bad     = 32'(frame_len_now) != V_TOTAL;
    // The line in progress when ACQUIRE is entered may be partial, so skip it.
    line_err_now  = hs_fall & ~skip_first & line_bad;
    watchdog      = (h_cnt == 10'd1023);
    good_next     = good_cnt + 8'd1;
    red_hit       = pixel_valid & (pix_rgb[11:8] != 4'd0);
  end

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state       <= SEARCH;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_act    <= 1'b0;
      frame_err   <= 1'b0;
      skip_first  <= 1'b0;
      good_cnt    <= '0;
      red_acc     <= '0;
      pixel_valid <= 1'b0;
      x_loc       <= '0;
      y_loc       <= '0;
      pix_rgb     <= '0;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      line_len    <= '0;
      frame_len   <= '0;
      red_pixels  <= '0;
    end else begin
      hs_q       <= hsync;
      vs_q       <= vsync;
      sync_err   <= 1'b0;
      frame_done <= vs_fall & (state == LOCKED);

      if (hs_fall)        h_cnt <= '0;
      else if (!watchdog) h_cnt <= h_cnt + 10'd1;
      if (hs_fall) line_len <= h_cnt + 10'd1;

      if (vs_fall)                           v_cnt <= '0;
      else if (hs_fall && v_cnt != 10'd1023) v_cnt <= v_cnt + 10'd1;
      if (vs_fall) frame_len <= frame_len_now[9:0];

      if (watchdog) begin
        state    <= SEARCH;
        locked   <= 1'b0;
        sync_err <= (state == LOCKED);
      end else begin
        case (state)
          SEARCH: begin
            if (vs_fall) begin
              state      <= ACQUIRE;
              good_cnt   <= '0;
              frame_err  <= 1'b0;
              skip_first <= 1'b1;
            end
          end
          ACQUIRE: begin
            if (hs_fall) skip_first <= 1'b0;
            if (vs_fall) begin
              frame_err <= 1'b0;
              if (!frame_err && !line_err_now && !frame_bad) begin
                good_cnt <= good_next;
                if (32'(good_next) >= LOCK_FRAMES) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end else if (line_err_now) begin
              frame_err <= 1'b1;
            end
          end
          LOCKED: begin
            if ((hs_fall && line_bad) || (vs_fall && frame_bad)) begin
              state      <= ACQUIRE;
              locked     <= 1'b0;
              sync_err   <= 1'b1;
              good_cnt   <= '0;
              frame_err  <= 1'b0;
              skip_first <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end

      if (hs_fall)      x_cnt <= '0;
      else if (blank_n) x_cnt <= x_cnt + 10'd1;

      if (hs_fall)      line_act <= 1'b0;
      else if (blank_n) line_act <= 1'b1;

      // Frame start clear wins over the end-of-line increment.
      if (vs_fall)                  y_cnt <= '0;
      else if (hs_fall && line_act) y_cnt <= y_cnt + 10'd1;

      pixel_valid <= locked & blank_n;
      x_loc       <= x_cnt;
      y_loc       <= y_cnt;
      pix_rgb     <= {red, green, blue};

      if (vs_fall) begin
        red_pixels <= red_acc;
        red_acc    <= '0;
      end else if (red_hit && red_acc != '1) begin
        red_acc <= red_acc + 19'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a scaled 64x24 timing (40x16 active
// region) so that many frames fit in a short run.
`default_nettype none

module tb_vga_capture;

  localparam int HT = 64;
  localparam int VT = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, blank_n = 1'b0;
  logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
  logic        pixel_valid, locked, frame_done, sync_err;
  logic [9:0]  x_loc, y_loc, line_len, frame_len;
  logic [11:0] pix_rgb;
  logic [18:0] red_pixels;

  int pass_cnt = 0, total_cnt = 0;
  int se_cnt, fd_cnt, valid_cnt, rgb_bad;
  int first_x, first_y, last_x, last_y;
  bit seen_first, err_seen;
  logic [9:0] err_ll;
  logic       err_lk;
  int se_total;

  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut (
    .clk_d(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .x_loc(x_loc), .y_loc(y_loc), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .sync_err(sync_err),
    .line_len(line_len), .frame_len(frame_len), .red_pixels(red_pixels)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    se_cnt = 0; fd_cnt = 0; valid_cnt = 0; rgb_bad = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    seen_first = 0; err_seen = 0; err_ll = '0; err_lk = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    se_cnt += int'(sync_err);
    fd_cnt += int'(frame_done);
    if (sync_err && !err_seen) begin
      err_seen = 1; err_ll = line_len; err_lk = locked;
    end
    if (pixel_valid) begin
      if (!seen_first) begin
        seen_first = 1; first_x = int'(x_loc); first_y = int'(y_loc);
      end
      last_x = int'(x_loc); last_y = int'(y_loc);
      valid_cnt++;
      if (pix_rgb !== {red, green, blue}) rgb_bad++;
    end
  endtask

  // One frame: hsync low 8 clocks, vsync low 2 lines, active lines 3..18, cols 12..51.
  task automatic run_frame(input int red_n, input int bad_line, input int rst_at);
    int len, k, pix;
    bit act;
    clear_stats();
    k = 0; pix = 0;
    for (int ln = 0; ln < VT; ln++) begin
      len = (ln == bad_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        act     = (ln >= 3) && (ln < 19) && (c >= 12) && (c < 52);
        rst     = (k == rst_at);
        hsync   = (c >= 8);
        vsync   = (ln >= 2);
        blank_n = act;
        red     = (act && pix < red_n) ? 4'hF : 4'h0;
        green   = c[3:0];
        blue    = ln[3:0];
        if (act) pix++;
        step();
        if (k == rst_at) begin
          rst = 1'b0;
          return;
        end
        k++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
    clear_stats();
    repeat (3) step();
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked);
    else pass_cnt++;
    total_cnt++;
    if ({pixel_valid, x_loc, y_loc, pix_rgb} !== 33'd0)
      $display("FAIL reset_pixel: got %b/%0d/%0d/%h want all 0", pixel_valid, x_loc, y_loc, pix_rgb);
    else pass_cnt++;
    total_cnt++;
    if ({frame_done, sync_err, line_len, frame_len, red_pixels} !== 41'd0)
      $display("FAIL reset_status: got fd=%b se=%b ll=%0d fl=%0d rp=%0d want all 0",
               frame_done, sync_err, line_len, frame_len, red_pixels);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    se_total = 0;
    run_frame(0, -1, -1); se_total += se_cnt;
    run_frame(0, -1, -1); se_total += se_cnt;
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL nom_locked_early: got %b want 0", locked);
    else pass_cnt++;
    run_frame(0, -1, -1); se_total += se_cnt;
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL nom_locked: got %b want 1", locked);
    else pass_cnt++;
    total_cnt++;
    if (line_len !== 10'd64) $display("FAIL nom_line_len: got %0d want 64", line_len);
    else pass_cnt++;
    total_cnt++;
    if (frame_len !== 10'd24) $display("FAIL nom_frame_len: got %0d want 24", frame_len);
    else pass_cnt++;
    total_cnt++;
    if (se_total !== 0) $display("FAIL nom_sync_err: got %0d pulses want 0", se_total);
    else pass_cnt++;
  endtask

  task automatic test_active();
    run_frame(0, -1, -1);
    total_cnt++;
    if (valid_cnt !== 640) $display("FAIL act_count: got %0d want 640", valid_cnt);
    else pass_cnt++;
    total_cnt++;
    if (first_x !== 0 || first_y !== 0)
      $display("FAIL act_first: got (%0d,%0d) want (0,0)", first_x, first_y);
    else pass_cnt++;
    total_cnt++;
    if (last_x !== 39 || last_y !== 15)
      $display("FAIL act_last: got (%0d,%0d) want (39,15)", last_x, last_y);
    else pass_cnt++;
    total_cnt++;
    if (rgb_bad !== 0) $display("FAIL act_rgb: got %0d wrong pixels want 0", rgb_bad);
    else pass_cnt++;
    total_cnt++;
    if (fd_cnt !== 1) $display("FAIL act_frame_done: got %0d pulses want 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_red();
    run_frame(100, -1, -1);
    total_cnt++;
    if (red_pixels !== 19'd0) $display("FAIL red_prev: got %0d want 0", red_pixels);
    else pass_cnt++;
    run_frame(0, -1, -1);
    total_cnt++;
    if (red_pixels !== 19'd100) $display("FAIL red_count: got %0d want 100", red_pixels);
    else pass_cnt++;
    total_cnt++;
    if (fd_cnt !== 1) $display("FAIL red_frame_done: got %0d pulses want 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bad_line();
    run_frame(0, 10, -1);
    total_cnt++;
    if (se_cnt !== 1) $display("FAIL bad_sync_err: got %0d pulses want 1", se_cnt);
    else pass_cnt++;
    total_cnt++;
    if (err_lk !== 1'b0) $display("FAIL bad_locked: got %b want 0", err_lk);
    else pass_cnt++;
    total_cnt++;
    if (err_ll !== 10'd63) $display("FAIL bad_line_len: got %0d want 63", err_ll);
    else pass_cnt++;
    run_frame(0, -1, -1);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL bad_relock_early: got %b want 0", locked);
    else pass_cnt++;
    run_frame(0, -1, -1);
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL bad_relock: got %b want 1", locked);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    run_frame(0, -1, 5 * HT + 20);
    total_cnt++;
    if ({pixel_valid, x_loc, y_loc, pix_rgb, locked} !== 34'd0)
      $display("FAIL mid_rst_pixel: got v=%b x=%0d y=%0d rgb=%h lk=%b want all 0",
               pixel_valid, x_loc, y_loc, pix_rgb, locked);
    else pass_cnt++;
    total_cnt++;
    if ({frame_done, sync_err, line_len, frame_len, red_pixels} !== 41'd0)
      $display("FAIL mid_rst_status: got fd=%b se=%b ll=%0d fl=%0d rp=%0d want all 0",
               frame_done, sync_err, line_len, frame_len, red_pixels);
    else pass_cnt++;
    run_frame(0, -1, -1);
    run_frame(0, -1, -1);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL mid_rst_early: got %b want 0", locked);
    else pass_cnt++;
    run_frame(0, -1, -1);
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL mid_rst_relock: got %b want 1", locked);
    else pass_cnt++;
  endtask

  task automatic test_watchdog();
    clear_stats();
    hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
    red = 4'd0; green = 4'd0; blue = 4'd0;
    repeat (1100) step();
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL wd_locked: got %b want 0", locked);
    else pass_cnt++;
    total_cnt++;
    if (se_cnt !== 1) $display("FAIL wd_sync_err: got %0d pulses want 1", se_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_active();
    test_red();
    test_bad_line();
    test_reset_midframe();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
